// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier gating the design-wide system reset.
// Define PLL_SUP_WATCHDOG_EN to add the lock watchdog, retry counting and FAULT state.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int MAX_A = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_C = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW    = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          sync1_r, lk_s;
  logic [3:0]    retry_nxt_s, retry_inc_s;
  logic [7:0]    lost_nxt_s;
  logic          wdog_exp_s;
  logic          pll_rst_nxt_s, sys_rst_nxt_s, ready_nxt_s, fault_nxt_s;

`ifdef PLL_SUP_WATCHDOG_EN
  assign wdog_exp_s = (cnt_r == CW'(LOCK_TIMEOUT - 1));
`else
  assign wdog_exp_s = 1'b0;
`endif

  // State, counters, lock synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_PLLRST;
      cnt_r     <= {CW{1'b0}};
      sync1_r   <= 1'b0;
      lk_s      <= 1'b0;
      retry_cnt <= 4'd0;
      lost_cnt  <= 8'd0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      sync1_r   <= pll_locked;
      lk_s      <= sync1_r;
      retry_cnt <= retry_nxt_s;
      lost_cnt  <= lost_nxt_s;
      pll_rst   <= pll_rst_nxt_s;
      sys_rst   <= sys_rst_nxt_s;
      ready     <= ready_nxt_s;
      fault     <= fault_nxt_s;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_cnt;
    lost_nxt_s  = lost_cnt;
    retry_inc_s = retry_cnt + 4'd1;
    if (relock_req) begin
      state_nxt_s = S_PLLRST;
      retry_nxt_s = 4'd0;
    end else begin
      case (state_r)
        S_PLLRST: begin
          if (cnt_r == CW'(PLL_RST_CYCLES - 1)) state_nxt_s = S_WAIT;
          else                                  state_nxt_s = S_PLLRST;
        end
        S_WAIT: begin
          // The WAIT cycle that first sees lk_s counts as the first qualified lock cycle.
          if (lk_s) begin
            if (STABLE_CYCLES <= 1) begin
              state_nxt_s = S_RUN;
              retry_nxt_s = 4'd0;
            end else begin
              state_nxt_s = S_STABLE;
            end
          end else if (wdog_exp_s) begin
            retry_nxt_s = retry_inc_s;
            if (retry_inc_s == 4'(MAX_RETRIES)) state_nxt_s = S_FAULT;
            else                                state_nxt_s = S_PLLRST;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            state_nxt_s = S_WAIT;
          end else if (cnt_r == CW'(STABLE_CYCLES - 1)) begin
            state_nxt_s = S_RUN;
            retry_nxt_s = 4'd0;
          end else begin
            state_nxt_s = S_STABLE;
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            state_nxt_s = S_PLLRST;
            if (lost_cnt == 8'hFF) lost_nxt_s = lost_cnt;
            else                   lost_nxt_s = lost_cnt + 8'd1;
          end else begin
            state_nxt_s = S_RUN;
          end
        end
        S_FAULT: state_nxt_s = S_FAULT;
        default: state_nxt_s = S_PLLRST;
      endcase
    end

    if (relock_req || (state_nxt_s != state_r)) begin
      if (state_nxt_s == S_STABLE) cnt_nxt_s = CW'(1);
      else                         cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // Output decode from the next state so outputs change on the entering edge
  always_comb begin
    pll_rst_nxt_s = 1'b1;
    sys_rst_nxt_s = 1'b1;
    ready_nxt_s   = 1'b0;
    fault_nxt_s   = 1'b0;
    case (state_nxt_s)
      S_PLLRST: pll_rst_nxt_s = 1'b1;
      S_WAIT:   pll_rst_nxt_s = 1'b0;
      S_STABLE: pll_rst_nxt_s = 1'b0;
      S_RUN: begin
        pll_rst_nxt_s = 1'b0;
        sys_rst_nxt_s = 1'b0;
        ready_nxt_s   = 1'b1;
      end
      S_FAULT:  fault_nxt_s = 1'b1;
      default:  pll_rst_nxt_s = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with short timing parameters.
// Watchdog scenarios run when PLL_SUP_WATCHDOG_EN is defined, otherwise the no-timeout scenario runs.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (32),
    .MAX_RETRIES   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .lost_cnt  (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise lock while in WAIT; ready must rise exactly 9 edges after the first sampling edge.
  task automatic lock_and_check(input string tag);
    pll_locked = 1'b1;
    tick(9);
    check({tag, "_ready_e8"}, {7'd0, ready}, 8'd0);
    check({tag, "_sysrst_e8"}, {7'd0, sys_rst}, 8'd1);
    tick(1);
    check({tag, "_ready_e9"}, {7'd0, ready}, 8'd1);
    check({tag, "_sysrst_e9"}, {7'd0, sys_rst}, 8'd0);
    check({tag, "_pllrst_e9"}, {7'd0, pll_rst}, 8'd0);
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    tick(3);
    check("rst_pll_rst", {7'd0, pll_rst}, 8'd1);
    check("rst_sys_rst", {7'd0, sys_rst}, 8'd1);
    check("rst_ready", {7'd0, ready}, 8'd0);
    check("rst_fault", {7'd0, fault}, 8'd0);
    check("rst_retry", {4'd0, retry_cnt}, 8'd0);
    check("rst_lost", lost_cnt, 8'd0);

    // Power-up: pll_rst pulse of 4 cycles, then lock 10 cycles after release
    reset = 1'b0;
    tick(3);
    check("pwr_pllrst_hi", {7'd0, pll_rst}, 8'd1);
    tick(1);
    check("pwr_pllrst_lo", {7'd0, pll_rst}, 8'd0);
    tick(6);
    lock_and_check("pwr");
    check("pwr_retry", {4'd0, retry_cnt}, 8'd0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    check("loss_ready_n1", {7'd0, ready}, 8'd1);
    tick(1);
    check("loss_sysrst_n2", {7'd0, sys_rst}, 8'd1);
    check("loss_pllrst_n2", {7'd0, pll_rst}, 8'd1);
    check("loss_ready_n2", {7'd0, ready}, 8'd0);
    check("loss_lost", lost_cnt, 8'd1);
    tick(4);
    check("loss_pllrst_width", {7'd0, pll_rst}, 8'd0);
    lock_and_check("relock1");

    // Software relock from RUN, then lock chatter during STABLE
    pll_locked = 1'b0;
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("req_pllrst", {7'd0, pll_rst}, 8'd1);
    check("req_sysrst", {7'd0, sys_rst}, 8'd1);
    check("req_lost", lost_cnt, 8'd1);
    tick(4);
    check("req_pllrst_lo", {7'd0, pll_rst}, 8'd0);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(3);
    check("chat_ready", {7'd0, ready}, 8'd0);
    check("chat_retry", {4'd0, retry_cnt}, 8'd0);
    check("chat_pllrst", {7'd0, pll_rst}, 8'd0);
    lock_and_check("chat");

    // relock_req coincident with lk_s drop in RUN
    pll_locked = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("coin_pllrst", {7'd0, pll_rst}, 8'd1);
    check("coin_ready", {7'd0, ready}, 8'd0);
    check("coin_lost", lost_cnt, 8'd1);
    tick(4);
    check("coin_pllrst_lo", {7'd0, pll_rst}, 8'd0);
    lock_and_check("coin");

    // Repeated losses: counter must saturate at 255
    for (int i = 0; i < 100; i++) begin
      pll_locked = 1'b0;
      tick(2);
      pll_locked = 1'b1;
      tick(18);
    end
    check("sat_lost_101", lost_cnt, 8'd101);
    check("sat_ready_101", {7'd0, ready}, 8'd1);
    for (int i = 0; i < 200; i++) begin
      pll_locked = 1'b0;
      tick(2);
      pll_locked = 1'b1;
      tick(18);
    end
    check("sat_lost_255", lost_cnt, 8'd255);
    check("sat_ready_255", {7'd0, ready}, 8'd1);

    // Lock never returns after a relock
    pll_locked = 1'b0;
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("wd_pllrst_t0", {7'd0, pll_rst}, 8'd1);
    check("wd_retry_t0", {4'd0, retry_cnt}, 8'd0);
    tick(4);
    check("wd_pllrst_t4", {7'd0, pll_rst}, 8'd0);
`ifdef PLL_SUP_WATCHDOG_EN
    tick(31);
    check("wd_pllrst_t35", {7'd0, pll_rst}, 8'd0);
    check("wd_retry_t35", {4'd0, retry_cnt}, 8'd0);
    tick(1);
    check("wd_pllrst_t36", {7'd0, pll_rst}, 8'd1);
    check("wd_retry_t36", {4'd0, retry_cnt}, 8'd1);
    tick(3);
    check("wd_pllrst_t39", {7'd0, pll_rst}, 8'd1);
    tick(1);
    check("wd_pllrst_t40", {7'd0, pll_rst}, 8'd0);
    tick(31);
    check("wd_fault_t71", {7'd0, fault}, 8'd0);
    check("wd_pllrst_t71", {7'd0, pll_rst}, 8'd0);
    tick(1);
    check("wd_fault_t72", {7'd0, fault}, 8'd1);
    check("wd_pllrst_t72", {7'd0, pll_rst}, 8'd1);
    check("wd_retry_t72", {4'd0, retry_cnt}, 8'd2);
    check("wd_sysrst_t72", {7'd0, sys_rst}, 8'd1);
    tick(10);
    check("wd_fault_hold", {7'd0, fault}, 8'd1);
    check("wd_pllrst_hold", {7'd0, pll_rst}, 8'd1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("wd_clr_fault", {7'd0, fault}, 8'd0);
    check("wd_clr_retry", {4'd0, retry_cnt}, 8'd0);
    check("wd_clr_pllrst", {7'd0, pll_rst}, 8'd1);
    tick(5);
    check("wd_wait_pllrst", {7'd0, pll_rst}, 8'd0);
`else
    tick(1000);
    check("nowd_pllrst", {7'd0, pll_rst}, 8'd0);
    check("nowd_fault", {7'd0, fault}, 8'd0);
    check("nowd_retry", {4'd0, retry_cnt}, 8'd0);
    check("nowd_sysrst", {7'd0, sys_rst}, 8'd1);
    check("nowd_ready", {7'd0, ready}, 8'd0);
`endif

    // Reset asserted mid-WAIT
    reset = 1'b1;
    tick(1);
    check("mid_rst_pllrst", {7'd0, pll_rst}, 8'd1);
    check("mid_rst_sysrst", {7'd0, sys_rst}, 8'd1);
    check("mid_rst_ready", {7'd0, ready}, 8'd0);
    check("mid_rst_fault", {7'd0, fault}, 8'd0);
    check("mid_rst_retry", {4'd0, retry_cnt}, 8'd0);
    check("mid_rst_lost", lost_cnt, 8'd0);
    reset = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
